// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game controller.
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_e;

  localparam logic [7:0] SCORE_MAX     = 8'h99;
  localparam int unsigned LIVES_DEFAULT = 3;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter that saturates at 99; clr has priority over inc.
module bcd2_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != SCORE_MAX)) begin
      if (q_q[3:0] == 4'd9) begin
        q_d = {q_q[7:4] + 4'd1, 4'd0};
      end else begin
        q_d = {q_q[7:4], q_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: FSM, lives and BCD score, countdown timer handshake.
// Optional pause input enabled by defining PONG_PAUSE_EN.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned LIVES = LIVES_DEFAULT,
  parameter int unsigned LW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    btn,
  input  logic          hit,
  input  logic          miss,
  input  logic          timer_up,
`ifdef PONG_PAUSE_EN
  input  logic          pause,
`endif
  output logic          timer_start,
  output logic          gra_still,
  output logic [1:0]    state,
  output logic [LW-1:0] lives,
  output logic [7:0]    score
);

  state_e        state_q, state_d;
  logic [LW-1:0] lives_q, lives_d;
  logic          score_clr, score_inc;
  logic          active;

`ifdef PONG_PAUSE_EN
  logic paused_q, paused_d;
  logic pause_q;

  always_comb begin
    paused_d = 1'b0;
    if (state_q == PLAY) begin
      paused_d = paused_q ^ (pause && !pause_q);
      if (state_d != PLAY) paused_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paused_q <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      paused_q <= paused_d;
      pause_q  <= pause;
    end
  end

  assign active = !paused_q;
`else
  assign active = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    timer_start = 1'b0;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    case (state_q)
      NEWGAME: begin
        lives_d   = LW'(LIVES);
        score_clr = 1'b1;
        if (btn != 2'b00) state_d = PLAY;
      end
      PLAY: begin
        // miss outranks a simultaneous hit
        if (active && miss) begin
          timer_start = 1'b1;
          if (lives_q > LW'(1)) begin
            lives_d = lives_q - LW'(1);
            state_d = NEWBALL;
          end else begin
            lives_d = '0;
            state_d = OVER;
          end
        end else if (active && hit) begin
          score_inc = 1'b1;
        end
      end
      NEWBALL: begin
        if (timer_up && (btn != 2'b00)) state_d = PLAY;
      end
      OVER: begin
        if (timer_up) begin
          state_d   = NEWGAME;
          lives_d   = LW'(LIVES);
          score_clr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NEWGAME;
      lives_q <= LW'(LIVES);
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
    end
  end

  bcd2_counter u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (score_clr),
    .inc     (score_inc),
    .q       (score)
  );

  assign gra_still = (state_q != PLAY) || !active;
  assign state     = state_q;
  assign lives     = lives_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (pause tests when PONG_PAUSE_EN is defined).
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] btn;
  logic       hit, miss, timer_up;
  logic       pause;
  logic       timer_start, gra_still;
  logic [1:0] state;
  logic [3:0] lives;
  logic [7:0] score;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.LIVES(3), .LW(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn         (btn),
    .hit         (hit),
    .miss        (miss),
    .timer_up    (timer_up),
`ifdef PONG_PAUSE_EN
    .pause       (pause),
`endif
    .timer_start (timer_start),
    .gra_still   (gra_still),
    .state       (state),
    .lives       (lives),
    .score       (score)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hit(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      hit = 1'b1;
      tick();
      hit = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; btn = '0; hit = 0; miss = 0; timer_up = 0; pause = 0;
    #12;
    reset_n = 1'b1;
    tick();
    total++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else passed++;
    total++; if (lives !== 4'd3) $display("FAIL reset_lives got=%0d exp=3", lives); else passed++;
    total++; if (score !== 8'h00) $display("FAIL reset_score got=%h exp=00", score); else passed++;
    total++; if (gra_still !== 1'b1) $display("FAIL reset_still got=%b exp=1", gra_still); else passed++;
    total++; if (timer_start !== 1'b0) $display("FAIL reset_tstart got=%b exp=0", timer_start); else passed++;
  endtask

  task automatic test_start();
    btn = 2'b01;
    tick();
    btn = 2'b00;
    total++; if (state !== 2'd1) $display("FAIL start_state got=%0d exp=1", state); else passed++;
    total++; if (gra_still !== 1'b0) $display("FAIL start_still got=%b exp=0", gra_still); else passed++;
  endtask

  task automatic test_score_and_async_reset();
    pulse_hit(12);
    total++; if (score !== 8'h12) $display("FAIL score12 got=%h exp=12", score); else passed++;
    pulse_hit(11);
    total++; if (score !== 8'h23) $display("FAIL score23 got=%h exp=23", score); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (state !== 2'd0) $display("FAIL areset_state got=%0d exp=0", state); else passed++;
    total++; if (score !== 8'h00) $display("FAIL areset_score got=%h exp=00", score); else passed++;
    total++; if (lives !== 4'd3) $display("FAIL areset_lives got=%0d exp=3", lives); else passed++;
    total++; if (gra_still !== 1'b1) $display("FAIL areset_still got=%b exp=1", gra_still); else passed++;
    total++; if (timer_start !== 1'b0) $display("FAIL areset_tstart got=%b exp=0", timer_start); else passed++;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_miss_newball();
    pulse_hit(3);
    total++; if (score !== 8'h03) $display("FAIL score03 got=%h exp=03", score); else passed++;
    miss = 1'b1;
    #1;
    total++; if (timer_start !== 1'b1) $display("FAIL miss_tstart got=%b exp=1", timer_start); else passed++;
    tick();
    miss = 1'b0;
    total++; if (timer_start !== 1'b0) $display("FAIL miss_tstart_width got=%b exp=0", timer_start); else passed++;
    total++; if (lives !== 4'd2) $display("FAIL miss_lives got=%0d exp=2", lives); else passed++;
    total++; if (state !== 2'd2) $display("FAIL miss_state got=%0d exp=2", state); else passed++;
    total++; if (gra_still !== 1'b1) $display("FAIL newball_still got=%b exp=1", gra_still); else passed++;
    hit = 1'b1; miss = 1'b1;
    #1;
    total++; if (timer_start !== 1'b0) $display("FAIL newball_ign_tstart got=%b exp=0", timer_start); else passed++;
    tick();
    hit = 1'b0; miss = 1'b0;
    total++; if (score !== 8'h03 || lives !== 4'd2) $display("FAIL newball_ignore got=%h/%0d exp=03/2", score, lives); else passed++;
    timer_up = 1'b1;
    tick();
    total++; if (state !== 2'd2) $display("FAIL newball_nobtn got=%0d exp=2", state); else passed++;
    btn = 2'b10;
    tick();
    btn = 2'b00; timer_up = 1'b0;
    total++; if (state !== 2'd1) $display("FAIL newball_resume got=%0d exp=1", state); else passed++;
    miss = 1'b1;
    tick();
    miss = 1'b0; btn = 2'b11;
    tick();
    timer_up = 1'b1;
    tick();
    timer_up = 1'b0; btn = 2'b00;
    total++; if (state !== 2'd1 || lives !== 4'd1) $display("FAIL second_ball got=%0d/%0d exp=1/1", state, lives); else passed++;
  endtask

  task automatic test_over();
    hit = 1'b1; miss = 1'b1;
    #1;
    total++; if (timer_start !== 1'b1) $display("FAIL over_tstart got=%b exp=1", timer_start); else passed++;
    tick();
    hit = 1'b0; miss = 1'b0;
    total++; if (score !== 8'h03) $display("FAIL hitmiss_score got=%h exp=03", score); else passed++;
    total++; if (lives !== 4'd0) $display("FAIL over_lives got=%0d exp=0", lives); else passed++;
    total++; if (state !== 2'd3) $display("FAIL over_state got=%0d exp=3", state); else passed++;
    total++; if (timer_start !== 1'b0) $display("FAIL over_tstart_width got=%b exp=0", timer_start); else passed++;
    hit = 1'b1; miss = 1'b1; btn = 2'b11;
    #1;
    total++; if (timer_start !== 1'b0) $display("FAIL over_ign_tstart got=%b exp=0", timer_start); else passed++;
    tick();
    hit = 1'b0; miss = 1'b0; btn = 2'b00;
    total++; if (state !== 2'd3 || score !== 8'h03 || lives !== 4'd0)
      $display("FAIL over_ignore got=%0d/%h/%0d exp=3/03/0", state, score, lives); else passed++;
    timer_up = 1'b1;
    tick();
    timer_up = 1'b0;
    total++; if (state !== 2'd0) $display("FAIL over_exit got=%0d exp=0", state); else passed++;
    total++; if (score !== 8'h00 || lives !== 4'd3) $display("FAIL over_restore got=%h/%0d exp=00/3", score, lives); else passed++;
  endtask

`ifdef PONG_PAUSE_EN
  task automatic test_pause();
    pause = 1'b1;
    tick();
    total++; if (gra_still !== 1'b1) $display("FAIL pause_still got=%b exp=1", gra_still); else passed++;
    miss = 1'b1;
    #1;
    total++; if (timer_start !== 1'b0) $display("FAIL pause_tstart got=%b exp=0", timer_start); else passed++;
    tick();
    miss = 1'b0;
    total++; if (state !== 2'd1 || lives !== 4'd3) $display("FAIL pause_miss got=%0d/%0d exp=1/3", state, lives); else passed++;
    pause = 1'b0; tick();
    pause = 1'b1; tick();
    pause = 1'b0; tick();
    total++; if (gra_still !== 1'b0) $display("FAIL unpause_still got=%b exp=0", gra_still); else passed++;
    pulse_hit(1);
    total++; if (score !== 8'h01) $display("FAIL unpause_hit got=%h exp=01", score); else passed++;
  endtask
`endif

  task automatic test_saturate();
    pulse_hit(99);
    total++; if (score !== 8'h99) $display("FAIL sat99 got=%h exp=99", score); else passed++;
    pulse_hit(1);
    total++; if (score !== 8'h99) $display("FAIL sat_hold got=%h exp=99", score); else passed++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_score_and_async_reset();
    test_start();
    test_miss_newball();
    test_over();
    test_start();
`ifdef PONG_PAUSE_EN
    test_pause();
`endif
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
